// File: rtl/spi_pkt_sequencer.sv
// APB master that streams 64-bit TX packets and collects 64-bit RX packets
// through the SPI/RF peripheral, one byte at a time (CONFIG, TX, CMD, STATUS poll, RX).
`timescale 1ns/1ps
module spi_pkt_sequencer #(
  parameter int         BUSY_BIT  = 0,
  parameter int         POLL_MAX  = 4096,
  parameter logic [7:0] CMD_START = 8'h02
) (
  input  logic        i_PCLK,
  input  logic        i_PRESET,
  input  logic [9:0]  i_BASE_ADDR,
  input  logic [1:0]  i_cfg_mode,
  input  logic [1:0]  i_cfg_slave,
  input  logic [1:0]  i_cfg_sck,
  input  logic        i_tx_valid,
  input  logic [63:0] i_tx_data,
  output logic        o_tx_ready,
  input  logic        i_pkt_rec,
  output logic [63:0] o_rx_data,
  output logic        o_rx_valid,
  output logic        o_rx_mode,
  output logic        o_busy,
  output logic        o_err,
  output logic        o_PSEL,
  output logic        o_PENABLE,
  output logic        o_PWRITE,
  output logic [15:0] o_PADDR,
  output logic [7:0]  o_PWDATA,
  input  logic [7:0]  i_PRDATA,
  input  logic        i_PREADY
);

  localparam int PCW = $clog2(POLL_MAX + 1);
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_MAX - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, NEXT = 2'd3} state_t;
  typedef enum logic [2:0] {OP_CFG = 3'd0, OP_DATA = 3'd1, OP_CMD = 3'd2,
                            OP_POLL = 3'd3, OP_RD = 3'd4} op_t;

  state_t         state_r;
  op_t            op_r;
  logic [2:0]     byte_cnt_r;
  logic [PCW-1:0] poll_cnt_r;
  logic [7:0]     cfg_r;
  logic [63:0]    tx_sr_r;
  logic [63:0]    rx_sr_r;
  logic           pend_r;
  logic           pkt_d_r;
  logic           fin_r;
  logic           abort_r;

  logic           rise_s;
  logic           rx_req_s;
  logic [5:0]     op_off_s;
  logic           op_wr_s;
  logic [7:0]     op_wdata_s;

  // RX request: a live rising edge counts so RX wins even in its first cycle
  always_comb begin
    rise_s   = i_pkt_rec & ~pkt_d_r;
    rx_req_s = pend_r | rise_s;
  end

  // Register offset, direction and write data of the op held in op_r
  always_comb begin
    op_off_s   = 6'h00;
    op_wr_s    = 1'b0;
    op_wdata_s = 8'h00;
    case (op_r)
      OP_CFG:  begin op_off_s = 6'h00; op_wr_s = 1'b1; op_wdata_s = cfg_r; end
      OP_DATA: begin op_off_s = 6'h04; op_wr_s = 1'b1;
                     op_wdata_s = o_rx_mode ? 8'h00 : tx_sr_r[63:56]; end
      OP_CMD:  begin op_off_s = 6'h0C; op_wr_s = 1'b1; op_wdata_s = CMD_START; end
      OP_POLL: begin op_off_s = 6'h00; op_wr_s = 1'b0; op_wdata_s = 8'h00; end
      OP_RD:   begin op_off_s = 6'h04; op_wr_s = 1'b0; op_wdata_s = 8'h00; end
      default: begin op_off_s = 6'h00; op_wr_s = 1'b0; op_wdata_s = 8'h00; end
    endcase
  end

  // Packet sequencer: arbitration, APB phases, op pointer, byte/poll counters
  always_ff @(posedge i_PCLK or posedge i_PRESET) begin
    if (i_PRESET) begin
      state_r    <= IDLE;
      op_r       <= OP_CFG;
      byte_cnt_r <= 3'd0;
      poll_cnt_r <= '0;
      cfg_r      <= 8'h00;
      tx_sr_r    <= 64'h0;
      rx_sr_r    <= 64'h0;
      pend_r     <= 1'b0;
      pkt_d_r    <= 1'b0;
      fin_r      <= 1'b0;
      abort_r    <= 1'b0;
      o_tx_ready <= 1'b0;
      o_rx_data  <= 64'h0;
      o_rx_valid <= 1'b0;
      o_rx_mode  <= 1'b0;
      o_busy     <= 1'b0;
      o_err      <= 1'b0;
      o_PSEL     <= 1'b0;
      o_PENABLE  <= 1'b0;
      o_PWRITE   <= 1'b0;
      o_PADDR    <= 16'h0000;
      o_PWDATA   <= 8'h00;
    end else begin
      pkt_d_r    <= i_pkt_rec;
      o_tx_ready <= 1'b0;
      o_rx_valid <= 1'b0;
      o_err      <= 1'b0;
      if (rise_s && !o_rx_mode) begin
        pend_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (rx_req_s || i_tx_valid) begin
            state_r    <= SETUP;
            op_r       <= OP_CFG;
            byte_cnt_r <= 3'd0;
            rx_sr_r    <= 64'h0;
            cfg_r      <= {2'b00, i_cfg_mode, i_cfg_slave, i_cfg_sck};
            o_busy     <= 1'b1;
            o_PSEL     <= 1'b1;
            o_PWRITE   <= 1'b1;
            o_PADDR    <= {i_BASE_ADDR, 6'h00};
            o_PWDATA   <= {2'b00, i_cfg_mode, i_cfg_slave, i_cfg_sck};
            if (rx_req_s) begin
              pend_r    <= 1'b0;
              o_rx_mode <= 1'b1;
            end else begin
              tx_sr_r    <= i_tx_data;
              o_tx_ready <= 1'b1;
            end
          end
        end
        SETUP: begin
          o_PENABLE <= 1'b1;
          state_r   <= ACCESS;
        end
        ACCESS: begin
          if (i_PREADY) begin
            o_PSEL    <= 1'b0;
            o_PENABLE <= 1'b0;
            state_r   <= NEXT;
            case (op_r)
              OP_CFG:  op_r <= OP_DATA;
              OP_DATA: begin
                op_r    <= OP_CMD;
                tx_sr_r <= {tx_sr_r[55:0], 8'h00};
              end
              OP_CMD: begin
                op_r       <= OP_POLL;
                poll_cnt_r <= '0;
              end
              OP_POLL: begin
                if (i_PRDATA[BUSY_BIT]) begin
                  if (poll_cnt_r == POLL_LAST) begin
                    abort_r <= 1'b1;
                  end else begin
                    poll_cnt_r <= poll_cnt_r + 1'b1;
                  end
                end else if (o_rx_mode) begin
                  op_r <= OP_RD;
                end else if (byte_cnt_r == 3'd7) begin
                  fin_r <= 1'b1;
                end else begin
                  byte_cnt_r <= byte_cnt_r + 3'd1;
                  op_r       <= OP_CFG;
                end
              end
              OP_RD: begin
                rx_sr_r <= {rx_sr_r[55:0], i_PRDATA};
                if (byte_cnt_r == 3'd7) begin
                  fin_r <= 1'b1;
                end else begin
                  byte_cnt_r <= byte_cnt_r + 3'd1;
                  op_r       <= OP_CFG;
                end
              end
              default: op_r <= OP_CFG;
            endcase
          end
        end
        NEXT: begin
          if (abort_r || fin_r) begin
            // A timed-out packet reports o_err instead of delivering data
            state_r    <= IDLE;
            abort_r    <= 1'b0;
            fin_r      <= 1'b0;
            o_busy     <= 1'b0;
            o_rx_mode  <= 1'b0;
            o_err      <= abort_r;
            o_rx_valid <= o_rx_mode & ~abort_r;
            if (o_rx_mode && !abort_r) begin
              o_rx_data <= rx_sr_r;
            end
          end else begin
            state_r  <= SETUP;
            o_PSEL   <= 1'b1;
            o_PWRITE <= op_wr_s;
            o_PADDR  <= {i_BASE_ADDR, op_off_s};
            o_PWDATA <= op_wdata_s;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule
